hazard_scoreboard: RTL
======================

Name: hazard_scoreboard

Overview:
- Parametrised successor of the ID-stage stall detector for the 5-stage MIPS pipeline.
- Keeps a per-register latency scoreboard instead of checking only the single ID/EX load. This supports variable-latency producers: LW with a slow memory, multi-cycle MUL/DIV.
- Generates PC/IF-ID write enables, the ID/EX bubble and the IF/ID flush for taken branches/jumps.
- Counts stall cycles for performance reporting.

Parameters:
- NUM_REGS, 32, number of architectural registers; register 0 is hard-wired zero and never tracked.
- REG_AW, 5, register address width; must satisfy 2**REG_AW >= NUM_REGS.
- LAT_W, 3, width of a latency value; maximum producer latency is 2**LAT_W-1.
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clock  in  1  system clock, all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- id_valid  in  1  ID stage holds a real instruction (not a bubble).
- id_rs  in  REG_AW  source register 1 of the ID instruction.
- id_rt  in  REG_AW  source register 2 of the ID instruction.
- id_uses_rs  in  1  the ID instruction reads rs.
- id_uses_rt  in  1  the ID instruction reads rt.
- id_we  in  1  the ID instruction writes a register (RegWrite).
- id_rd  in  REG_AW  destination register, already RegDst-muxed.
- id_lat  in  LAT_W  cycles after issue before the result is forwardable to EX: 0 = ALU, 1 = classic LW, >1 = slow unit.
- branch_taken  in  1  branch/jump resolved taken in ID (PCSrc | Jump).
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID register write enable.
- bubble_idex  out  1  insert a NOP into ID/EX.
- flush_ifid  out  1  squash the instruction currently in IF/ID.
- stall_count  out  CNT_W  saturating count of stall cycles since reset.

Behaviour:
- State: one LAT_W-bit counter pend[r] for r = 1..NUM_REGS-1, plus stall_count. pend[0] is constant 0.
- raw = id_valid & ((id_uses_rs & id_rs!=0 & pend[id_rs]!=0) | (id_uses_rt & id_rt!=0 & pend[id_rt]!=0)).
- waw = id_valid & id_we & id_rd!=0 & (id_lat < pend[id_rd]). This blocks a short-latency write from overtaking an older long one.
- stall = raw | waw. It is combinational from registered state and the ID inputs.
- Outputs:
  - pc_write = ifid_write = ~stall.
  - bubble_idex = stall | flush_ifid.
  - flush_ifid = branch_taken & ~stall. A branch waiting on its operands is not yet resolved, so branch_taken is ignored while stalled.
- issue = id_valid & ~stall. An instruction leaves ID at the next edge only when issue=1.
- Per edge, for each r != 0:
  - If issue & id_we & id_rd==r, then pend[r] <= id_lat. This overrides the decrement in the same cycle; id_lat=0 leaves the register untracked.
  - Else if pend[r]!=0, then pend[r] <= pend[r]-1.
  - Else hold.
- Result: a consumer issued immediately after a producer with latency L stalls exactly L cycles. With L=1 this is the classic single load-use bubble.
- stall_count increments by 1 on every edge with stall=1 and saturates at all-ones; it never wraps.
- Simultaneous events:
  - stall and branch_taken in the same cycle: stall wins, flush_ifid=0.
  - raw and waw in the same cycle: a single stall.
  - rs==rt: the hazard is counted once.
- Reset, including in the middle of a stall: at the edge with reset=1, all pend clear to 0 and stall_count clears to 0.
- While reset is high, outputs are forced to pc_write=1, ifid_write=1, bubble_idex=0, flush_ifid=0, regardless of inputs.
- Writes to r0 are never recorded. Reads of r0 never stall.

Test Plan:
- LW $8 (lat 1) issued, next cycle ADD uses rs=8 -> exactly 1 cycle with pc_write=0, ifid_write=0, bubble_idex=1. The ADD issues the following cycle; stall_count=1.
- DIV $9 (lat 5), then dependent SUB rt=9 -> 5 consecutive stall cycles; stall_count=5. An independent instruction (rs=3, rt=4) right after DIV issues with no stall.
- DIV $9 (lat 5), then ADDI $9 (lat 0) -> WAW stall until pend[9]=0 (5 cycles), then the ADDI issues.
- branch_taken=1 with no hazard -> flush_ifid=1 and bubble_idex=1 for 1 cycle. With a concurrent LW-use hazard on the branch's rs -> flush_ifid=0 during the stall cycle and 1 in the following cycle.
- LW $0, then a consumer with rs=0 -> no stall; pend unchanged.
- reset asserted mid DIV-stall (pend[9]=3) -> the next cycle has all pend=0, stall_count=0, and the dependent instruction issues. Separately, force 2**CNT_W+2 stall cycles -> stall_count holds at all-ones.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: per-register latency tracking,
// stall/flush control and a saturating stall-cycle counter.
module hazard_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = 5,
    parameter int LAT_W    = 3,
    parameter int CNT_W    = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_we,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [LAT_W-1:0]  id_lat,
    input  logic              branch_taken,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              bubble_idex,
    output logic              flush_ifid,
    output logic [CNT_W-1:0]  stall_count
);

    logic [LAT_W-1:0] pend [NUM_REGS];
    logic [LAT_W-1:0] pend_rs;
    logic [LAT_W-1:0] pend_rt;
    logic [LAT_W-1:0] pend_rd;
    logic             raw;
    logic             waw;
    logic             stall;
    logic             issue;
    logic             flush;

    assign pend_rs = pend[id_rs];
    assign pend_rt = pend[id_rt];
    assign pend_rd = pend[id_rd];

    // r0 is never tracked, so its reads/writes are masked here too
    assign raw = id_valid
               & ((id_uses_rs & (id_rs != '0) & (pend_rs != '0))
               |  (id_uses_rt & (id_rt != '0) & (pend_rt != '0)));

    // a shorter-latency write must not retire ahead of an older one
    assign waw = id_valid & id_we & (id_rd != '0) & (id_lat < pend_rd);

    assign stall = raw | waw;
    assign issue = id_valid & ~stall;
    assign flush = branch_taken & ~stall;

    assign pc_write    = reset | ~stall;
    assign ifid_write  = reset | ~stall;
    assign flush_ifid  = ~reset & flush;
    assign bubble_idex = ~reset & (stall | flush);

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                pend[r] <= '0;
            end
            stall_count <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (r == 0) begin
                    pend[r] <= '0;
                end else if (issue && id_we && id_rd == REG_AW'(r)) begin
                    pend[r] <= id_lat;
                end else if (pend[r] != '0) begin
                    pend[r] <= pend[r] - 1'b1;
                end
            end
            if (stall && stall_count != '1) begin
                stall_count <= stall_count + 1'b1;
            end
        end
    end

endmodule
